// File: rtl/cache_pkg.sv
// Shared constants, FSM state type and address-field helpers for the cache
// miss path.
package cache_pkg;

  localparam int WAYS            = 4;
  localparam int LINE_SIZE_BYTES = 64;
  localparam int TAG_BITS        = 18;
  localparam int INDEX_BITS      = 8;
  localparam int OFFSET_BITS     = 6;
  localparam int DATA_WIDTH      = 32;
  localparam int ADDRESS_WIDTH   = 32;

  localparam int LINE_SIZE_BITS = LINE_SIZE_BYTES * 8;
  localparam int WORDS          = LINE_SIZE_BITS / DATA_WIDTH;
  localparam int WORD_CNT_BITS  = $clog2(WORDS);
  localparam int WAY_BITS       = $clog2(WAYS);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    WB,
    FILL,
    COMMIT
  } state_t;

  function automatic logic [TAG_BITS-1:0] addr_tag(input logic [ADDRESS_WIDTH-1:0] addr);
    return addr[ADDRESS_WIDTH-1 -: TAG_BITS];
  endfunction

  function automatic logic [INDEX_BITS-1:0] addr_index(input logic [ADDRESS_WIDTH-1:0] addr);
    return addr[OFFSET_BITS +: INDEX_BITS];
  endfunction

endpackage

// File: rtl/victim_select.sv
// Combinational victim choice: lowest invalid way, else lowest way not
// recently used, else way 0. Also usable by the hit-path LRU updater.
module victim_select
  import cache_pkg::*;
(
  input  logic [WAYS-1:0]     valid,
  input  logic [WAYS-1:0]     lru,
  output logic [WAY_BITS-1:0] way
);

  logic                found_invalid;
  logic [WAY_BITS-1:0] invalid_way;
  logic [WAY_BITS-1:0] old_way;

  // Scanning downwards lets the lowest matching index win.
  always_comb begin
    found_invalid = 1'b0;
    invalid_way   = '0;
    old_way       = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        found_invalid = 1'b1;
        invalid_way   = WAY_BITS'(i);
      end
      if (!lru[i]) begin
        old_way = WAY_BITS'(i);
      end
    end
    way = found_invalid ? invalid_way : old_way;
  end

endmodule

// File: rtl/cache_miss_sequencer.sv
// Miss controller: victim selection, dirty writeback, line fill and commit.
// Optional CACHE_MISS_PERF_EN adds saturating miss/writeback counters.
module cache_miss_sequencer
  import cache_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            miss_valid,
  output logic                            miss_ready,
  input  logic [ADDRESS_WIDTH-1:0]        miss_addr,
  input  logic [WAYS-1:0]                 way_valid,
  input  logic [WAYS-1:0]                 way_dirty,
  input  logic [WAYS-1:0]                 way_lru,
  input  logic [WAYS*TAG_BITS-1:0]        way_tags,
  input  logic [WAYS*LINE_SIZE_BITS-1:0]  way_lines,
  output logic                            mem_req,
  output logic                            mem_we,
  output logic [ADDRESS_WIDTH-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  input  logic                            mem_ack,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  output logic                            fill_we,
  output logic [INDEX_BITS-1:0]           fill_index,
  output logic [WAY_BITS-1:0]             fill_way,
  output logic [TAG_BITS-1:0]             fill_tag,
  output logic [LINE_SIZE_BITS-1:0]       fill_line,
`ifdef CACHE_MISS_PERF_EN
  output logic                            busy,
  output logic [31:0]                     perf_miss_cnt,
  output logic [31:0]                     perf_wb_cnt
`else
  output logic                            busy
`endif
);

  state_t                    state;
  state_t                    next_state;
  logic [TAG_BITS-1:0]       tag_q;
  logic [TAG_BITS-1:0]       vic_tag_q;
  logic [INDEX_BITS-1:0]     index_q;
  logic [WAY_BITS-1:0]       way_q;
  logic [WAY_BITS-1:0]       sel_way;
  logic [LINE_SIZE_BITS-1:0] vic_line_q;
  logic [LINE_SIZE_BITS-1:0] line_buf;
  logic [WORD_CNT_BITS-1:0]  cnt;
  logic                      last_word;

  victim_select u_victim_select (
    .valid (way_valid),
    .lru   (way_lru),
    .way   (sel_way)
  );

  assign last_word  = (cnt == WORD_CNT_BITS'(WORDS - 1));
  assign fill_index = index_q;
  assign fill_way   = way_q;
  assign fill_tag   = tag_q;
  assign fill_line  = line_buf;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    miss_ready = 1'b0;
    busy       = 1'b1;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    fill_we    = 1'b0;
    unique case (state)
      IDLE: begin
        miss_ready = 1'b1;
        busy       = 1'b0;
        if (miss_valid) next_state = SELECT;
      end
      SELECT: begin
        next_state = (way_valid[sel_way] && way_dirty[sel_way]) ? WB : FILL;
      end
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {vic_tag_q, index_q, cnt, 2'b00};
        mem_wdata = vic_line_q[cnt*DATA_WIDTH +: DATA_WIDTH];
        if (mem_ack && last_word) next_state = FILL;
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {tag_q, index_q, cnt, 2'b00};
        if (mem_ack && last_word) next_state = COMMIT;
      end
      COMMIT: begin
        fill_we    = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The word counter wraps on the last word, so FILL always starts at word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q      <= '0;
      index_q    <= '0;
      way_q      <= '0;
      vic_tag_q  <= '0;
      vic_line_q <= '0;
      line_buf   <= '0;
      cnt        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (miss_valid) begin
            tag_q   <= addr_tag(miss_addr);
            index_q <= addr_index(miss_addr);
          end
        end
        SELECT: begin
          way_q      <= sel_way;
          vic_tag_q  <= way_tags[sel_way*TAG_BITS +: TAG_BITS];
          vic_line_q <= way_lines[sel_way*LINE_SIZE_BITS +: LINE_SIZE_BITS];
          cnt        <= '0;
        end
        WB: begin
          if (mem_ack) cnt <= cnt + 1'b1;
        end
        FILL: begin
          if (mem_ack) begin
            cnt                                     <= cnt + 1'b1;
            line_buf[cnt*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CACHE_MISS_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_miss_cnt <= '0;
      perf_wb_cnt   <= '0;
    end else begin
      if (state == COMMIT && perf_miss_cnt != '1)
        perf_miss_cnt <= perf_miss_cnt + 32'd1;
      if (state == SELECT && next_state == WB && perf_wb_cnt != '1)
        perf_wb_cnt <= perf_wb_cnt + 32'd1;
    end
  end
`endif

endmodule
